// File: rtl/input_pio_slave.sv
// Avalon-MM input PIO: synchronized, per-bit debounced level register plus sticky edge capture.
// Define INPUT_PIO_IRQ_EN to build the MASK register and the level interrupt; otherwise MASK reads 0 and irq is 0.
module input_pio_slave #(
  parameter int unsigned      WIDTH           = 10,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IDLE_VALUE      = WIDTH'(10'b11_0000_0000)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             avs_chipselect,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [WIDTH-1:0] in_raw,
  output logic             irq
);

  localparam int unsigned    CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_POL  = 2'd3;

  logic             rd_en_c;
  logic             wr_en_c;
  logic [WIDTH-1:0] wdata_c;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] stable_prev_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] edge_set_c;
  logic [WIDTH-1:0] edge_clr_c;
  logic [WIDTH-1:0] pol_q;
  logic [WIDTH-1:0] mask_q;
  logic [31:0]      rdata_c;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign rd_en_c = avs_chipselect & avs_read;
  assign wr_en_c = avs_chipselect & avs_write;
  assign wdata_c = avs_writedata[WIDTH-1:0];

  // Two-flop synchronizer for the asynchronous pad inputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= IDLE_VALUE;
      sync2_q <= IDLE_VALUE;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stable_q      <= IDLE_VALUE;
      stable_prev_q <= IDLE_VALUE;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  // A debounced transition toward the selected polarity sets EDGE; a coincident W1C loses.
  always_comb begin
    edge_set_c = (stable_q ^ stable_prev_q) & (stable_q ^ pol_q);
    edge_clr_c = '0;
    if (wr_en_c && (avs_address == ADDR_EDGE)) begin
      edge_clr_c = wdata_c;
    end
    edge_d = (edge_q & ~edge_clr_c) | edge_set_c;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      edge_q <= '0;
      pol_q  <= '0;
    end else begin
      edge_q <= edge_d;
      if (wr_en_c && (avs_address == ADDR_POL)) begin
        pol_q <= wdata_c;
      end
    end
  end

`ifdef INPUT_PIO_IRQ_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_en_c && (avs_address == ADDR_MASK)) begin
        mask_q <= wdata_c;
      end
      irq <= |(edge_q & mask_q);
    end
  end
`else
  assign mask_q = '0;
  assign irq    = 1'b0;
`endif

  // Read mux; readdata is captured only on a selected read and held otherwise.
  always_comb begin
    rdata_c = '0;
    case (avs_address)
      ADDR_DATA: rdata_c = 32'(stable_q);
      ADDR_EDGE: rdata_c = 32'(edge_q);
      ADDR_MASK: rdata_c = 32'(mask_q);
      ADDR_POL:  rdata_c = 32'(pol_q);
      default:   rdata_c = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      avs_readdata <= '0;
    end else if (rd_en_c) begin
      avs_readdata <= rdata_c;
    end
  end

endmodule

// File: tb/tb_input_pio_slave.sv
// Directed bench for input_pio_slave (DEBOUNCE_CYCLES=4); covers both INPUT_PIO_IRQ_EN builds.
module tb_input_pio_slave;

`ifdef INPUT_PIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        avs_chipselect = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [9:0]  in_raw = 10'h300;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  input_pio_slave #(
    .WIDTH(10),
    .DEBOUNCE_CYCLES(4),
    .IDLE_VALUE(10'h300)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .avs_chipselect(avs_chipselect),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .in_raw(in_raw),
    .irq(irq)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_address    = a;
    tick(1);
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    avs_address    = a;
    avs_writedata  = d;
    tick(1);
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(1);
    vectors++;
    if (avs_readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_readdata: got %h expected %h", avs_readdata, 32'h0);
    end
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h300) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected %h", d, 32'h300);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    for (int a = 1; a < 4; a++) begin
      bus_read(2'(a), d);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h expected %h", a, d, 32'h0);
      end
    end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    in_raw = 10'h301;
    tick(3);
    in_raw = 10'h300;
    tick(10);
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h300) begin
      miscompares++;
      $display("FAIL glitch_data: got %h expected %h", d, 32'h300);
    end
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL glitch_edge: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_rising;
    logic [31:0] d;
    in_raw = 10'h301;
    tick(10);
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h301) begin
      miscompares++;
      $display("FAIL rise_data: got %h expected %h", d, 32'h301);
    end
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h001) begin
      miscompares++;
      $display("FAIL rise_edge: got %h expected %h", d, 32'h001);
    end
    // DATA is read-only and a write without chipselect must be ignored
    bus_write(2'd0, 32'h0);
    avs_write = 1'b1; avs_address = 2'd1; avs_writedata = 32'h1;
    tick(1);
    avs_write = 1'b0;
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h301) begin
      miscompares++;
      $display("FAIL data_ro: got %h expected %h", d, 32'h301);
    end
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h001) begin
      miscompares++;
      $display("FAIL edge_no_cs: got %h expected %h", d, 32'h001);
    end
    bus_write(2'd1, 32'h001);
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL rise_w1c: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_falling_irq;
    logic [31:0] d;
    bus_write(2'd3, 32'h100);
    bus_write(2'd2, 32'h100);
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h100) begin
      miscompares++;
      $display("FAIL pol_rw: got %h expected %h", d, 32'h100);
    end
    bus_read(2'd2, d);
    vectors++;
    if (d !== (IRQ_EN ? 32'h100 : 32'h0)) begin
      miscompares++;
      $display("FAIL mask_rw: got %h expected %h", d, IRQ_EN ? 32'h100 : 32'h0);
    end
    // stable flips on the 6th edge, EDGE on the 7th, irq on the 8th
    in_raw = 10'h201;
    tick(7);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_early: got %b expected 0", irq);
    end
    tick(1);
    vectors++;
    if (irq !== IRQ_EN) begin
      miscompares++;
      $display("FAIL irq_set: got %b expected %b", irq, IRQ_EN);
    end
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h100) begin
      miscompares++;
      $display("FAIL fall_edge: got %h expected %h", d, 32'h100);
    end
    bus_write(2'd1, 32'h100);
    vectors++;
    if (irq !== IRQ_EN) begin
      miscompares++;
      $display("FAIL irq_hold: got %b expected %b", irq, IRQ_EN);
    end
    tick(1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
    if (!IRQ_EN) begin
      bus_write(2'd2, 32'h3FF);
      bus_read(2'd2, d);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++;
        $display("FAIL mask_disabled: got %h expected %h", d, 32'h0);
      end
    end
  endtask

  task automatic test_set_w1c_collision;
    logic [31:0] d;
    in_raw = 10'h200;
    tick(10);
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL fall_ignored_pol0: got %h expected %h", d, 32'h0);
    end
    // W1C lands on the same edge that sets EDGE bit0
    in_raw = 10'h201;
    tick(6);
    bus_write(2'd1, 32'h001);
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h001) begin
      miscompares++;
      $display("FAIL set_beats_w1c: got %h expected %h", d, 32'h001);
    end
    tick(2);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_unmasked_bit: got %b expected 0", irq);
    end
  endtask

  task automatic test_reset_mid_debounce;
    logic [31:0] d;
    // EDGE bit0 is still pending; start debouncing bit9 low and reset at count 2
    in_raw = 10'h001;
    tick(4);
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_irq: got %b expected 0", irq);
    end
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h300) begin
      miscompares++;
      $display("FAIL mid_reset_data: got %h expected %h", d, 32'h300);
    end
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_edge: got %h expected %h", d, 32'h0);
    end
    bus_read(2'd2, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_mask: got %h expected %h", d, 32'h0);
    end
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_pol: got %h expected %h", d, 32'h0);
    end
    tick(10);
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h001) begin
      miscompares++;
      $display("FAIL redebounce_data: got %h expected %h", d, 32'h001);
    end
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h001) begin
      miscompares++;
      $display("FAIL redebounce_edge: got %h expected %h", d, 32'h001);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rising();
    test_falling_irq();
    test_set_w1c_collision();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_pio_slave.md
# input_pio_slave

Avalon-MM slave peripheral that the Nios II reads to sample the board's slide switches and push buttons; it is the responder side of the bus the processor initiates on. Raw pad inputs are synchronized, debounced per bit, and exposed as a level register. Selected edges are latched in a sticky capture register with an optional maskable interrupt. It sits inside the SoC fabric beside the LED output PIO and is driven from `SW` and `KEY` at the top level.

## Interface
- `WIDTH`, 10: number of input bits; the top level maps {KEY[1:0], SW[7:0]}.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable `Clk` cycles required to accept a new level (1 ms at 50 MHz); must be ≥ 2.
- `IDLE_VALUE`, 10'b11_0000_0000: reset value of the synchronizer and debounced level (KEYs idle high).
- `Clk`  in  1  system clock (50 MHz).
- `Reset`  in  1  asynchronous, active-high reset.
- `avs_chipselect`  in  1  slave select.
- `avs_address`  in  2  word address of register.
- `avs_read`  in  1  read strobe, qualified by chipselect.
- `avs_write`  in  1  write strobe, qualified by chipselect.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  registered read data.
- `in_raw`  in  WIDTH  asynchronous pad inputs.
- `irq`  out  1  level interrupt to Nios II.

## Operation
- Register map (word addresses; bits above WIDTH-1 read 0, writes ignored):
  - 0 DATA, RO: debounced level `stable`.
  - 1 EDGE, W1C: sticky capture; writing 1 clears that bit, writing 0 has no effect.
  - 2 MASK, RW: interrupt enable per bit (see Configuration).
  - 3 POL, RW: per-bit capture polarity; 1 = falling edge, 0 = rising edge.
- Writes to DATA are ignored. A read or write without `avs_chipselect` has no effect.
- Synchronizer: two flops per bit, reset to `IDLE_VALUE`.
- Debounce, per bit, with a counter of `$clog2(DEBOUNCE_CYCLES)` bits:
  - If the synced bit equals `stable`, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the bit still differs, `stable` takes the new value and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles leaves `stable` unchanged.
- Edge detect: a `stable` transition matching the POL bit sets the EDGE bit.
- Set and W1C of the same bit in the same cycle: set wins, so the bit stays 1.
- Reset values: `stable`=`IDLE_VALUE`, all counters 0, EDGE 0, MASK 0, POL 0, `avs_readdata` 0, `irq` 0.
- Reset asserted mid-debounce discards the partial count, with no edge captured.

## Timing
- Read latency is 1: `avs_readdata` is valid the cycle after `avs_read` & `avs_chipselect` and holds until the next read. There is no waitrequest.
- Writes take effect at the write cycle's clock edge; a read in the next cycle returns the new value.
- `in_raw` change to `stable` change is 2 (sync) + `DEBOUNCE_CYCLES` cycles when the input is clean.
- `stable` change to EDGE bit set is 1 cycle.
- EDGE/MASK change to `irq` is 1 cycle; `irq` is registered.
- `irq` = registered |(EDGE & MASK). It deasserts 1 cycle after the last enabled EDGE bit is cleared or masked.

## Configuration
- `INPUT_PIO_IRQ_EN` defined: MASK register and `irq` logic are implemented as described.
- `INPUT_PIO_IRQ_EN` undefined:
  - MASK reads 0 and ignores writes.
  - `irq` is tied to 0.
  - EDGE capture and W1C are unchanged.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `WIDTH`=10, `IDLE_VALUE`=10'h300.
- Reset release, read addr 0 → readdata 0x300 one cycle later; `irq`=0; read addr 1/2/3 → 0.
- Drive `in_raw` bit0 high for 3 cycles then low → DATA stays 0x300, EDGE stays 0 (glitch rejected).
- Hold bit0 high ≥ 7 cycles → DATA=0x301; EDGE=0x001 (POL=0, rising). Write 0x001 to addr 1 → EDGE reads 0.
- Write POL=0x100, MASK=0x100; drive bit8 low ≥ 7 cycles → EDGE=0x100, `irq`=1 one cycle after the EDGE set. Write 0x100 to addr 1 → `irq`=0 one cycle later.
- W1C to EDGE bit0 in the same cycle a new rising edge sets bit0 → EDGE bit0 reads 1.
- Assert `Reset` mid-debounce (count 2) with edges pending → all registers return to reset values; on release, DATA re-debounces from `IDLE_VALUE`. Build without `INPUT_PIO_IRQ_EN`: write MASK=0x3FF → reads 0, `irq` stays 0 with EDGE non-zero.
